// File: rtl/exp_norm_dec_phase.sv
// Left-normalization stage: shifts the significand up one bit per clock while
// decrementing the exponent, stopping on hidden bit set, zero, or denormal range.
module exp_norm_dec_phase #(
   parameter int W_Exp = 8,
   parameter int W_Sig = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W_Exp-1:0] exp_in,
   input  logic [W_Sig-1:0] sgf_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [W_Exp-1:0] exp_norm,
   output logic [W_Sig-1:0] sgf_norm,
   output logic             underflow_flag,
   output logic             zero_flag
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NORM = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [W_Exp-1:0] r_exp;
   logic [W_Sig-1:0] r_sgf;
   logic [W_Exp-1:0] r_exp_norm;
   logic [W_Sig-1:0] r_sgf_norm;
   logic             r_uf;
   logic             r_zf;

   logic w_zero;
   logic w_msb;
   logic w_low;

   assign w_zero = (r_sgf == '0);
   assign w_msb  = r_sgf[W_Sig-1];
   // Field 0 and field 1 share a scale, so shifting stops at exponent 1.
   assign w_low  = (r_exp <= W_Exp'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_exp      <= '0;
         r_sgf      <= '0;
         r_exp_norm <= '0;
         r_sgf_norm <= '0;
         r_uf       <= 1'b0;
         r_zf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_exp   <= exp_in;
                  r_sgf   <= sgf_in;
                  r_state <= S_NORM;
               end
            end
            S_NORM: begin
               if (w_zero) begin
                  r_exp_norm <= '0;
                  r_sgf_norm <= '0;
                  r_zf       <= 1'b1;
                  r_uf       <= 1'b0;
                  r_state    <= S_DONE;
               end else if (w_msb) begin
                  r_exp_norm <= r_exp;
                  r_sgf_norm <= r_sgf;
                  r_zf       <= 1'b0;
                  r_uf       <= 1'b0;
                  r_state    <= S_DONE;
               end else if (w_low) begin
                  r_exp_norm <= '0;
                  r_sgf_norm <= r_sgf;
                  r_zf       <= 1'b0;
                  r_uf       <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_sgf <= {r_sgf[W_Sig-2:0], 1'b0};
                  r_exp <= r_exp - W_Exp'(1);
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready          = (r_state == S_IDLE);
   assign busy           = (r_state == S_NORM);
   assign done           = (r_state == S_DONE);
   assign exp_norm       = r_exp_norm;
   assign sgf_norm       = r_sgf_norm;
   assign underflow_flag = r_uf;
   assign zero_flag      = r_zf;

endmodule
